// File: rtl/bp_clint_mmio.sv
// bp_clint_mmio: core-local interruptor (msip, mtimecmp, meip per hart,
// shared prescaled mtime) behind a one-outstanding valid/ready MMIO port.
//
// Ports:
//   clk_i, reset_i           clock, asynchronous active-high reset
//   cmd_v_i / cmd_ready_o    command handshake
//   cmd_w_i, cmd_size_i      write flag, size (2'b10=4B, 2'b11=8B)
//   cmd_addr_i, cmd_data_i   byte offset in window, write data
//   cmd_tag_i                tag echoed on the response
//   resp_v_o / resp_yumi_i   response handshake
//   resp_data_o, resp_tag_o  read data (0 for writes/errors), tag
//   resp_err_o               unmapped address or illegal size/alignment
//   soft_irq_o               msip[i]
//   timer_irq_o              mtime >= mtimecmp[i] (registered)
//   external_irq_o           meip[i]

module bp_clint_mmio #(
    parameter int          num_core_p       = 1,
    parameter int          addr_width_p     = 16,
    parameter int          tag_width_p      = 8,
    parameter int          timer_div_p      = 1,
    parameter logic [63:0] reset_mtimecmp_p = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                    clk_i,
    input  logic                    reset_i,

    input  logic                    cmd_v_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_w_i,
    input  logic [1:0]              cmd_size_i,
    input  logic [addr_width_p-1:0] cmd_addr_i,
    input  logic [63:0]             cmd_data_i,
    input  logic [tag_width_p-1:0]  cmd_tag_i,

    output logic                    resp_v_o,
    input  logic                    resp_yumi_i,
    output logic [63:0]             resp_data_o,
    output logic [tag_width_p-1:0]  resp_tag_o,
    output logic                    resp_err_o,

    output logic [num_core_p-1:0]   soft_irq_o,
    output logic [num_core_p-1:0]   timer_irq_o,
    output logic [num_core_p-1:0]   external_irq_o
);

    localparam int hart_w_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam int pre_w_lp  = (timer_div_p > 1) ? $clog2(timer_div_p) : 1;

    localparam logic [pre_w_lp-1:0] pre_max_lp = pre_w_lp'(timer_div_p - 1);

    localparam logic [31:0] msip_end_lp  = 32'(4 * num_core_p);
    localparam logic [31:0] cmp_base_lp  = 32'h0000_4000;
    localparam logic [31:0] cmp_end_lp   = 32'h0000_4000 + 32'(8 * num_core_p);
    localparam logic [31:0] mtime_lp     = 32'h0000_BFF8;
    localparam logic [31:0] meip_base_lp = 32'h0000_C000;
    localparam logic [31:0] meip_end_lp  = 32'h0000_C000 + 32'(4 * num_core_p);

    typedef enum logic {
        e_ready,
        e_resp
    } state_e;

    state_e state_r, state_n;

    logic [num_core_p-1:0] msip_r;
    logic [num_core_p-1:0] meip_r;
    logic [num_core_p-1:0] timer_irq_r;
    logic [63:0]           mtimecmp_r [num_core_p];
    logic [63:0]           mtime_r;
    logic [pre_w_lp-1:0]   pre_r;

    logic [63:0]            resp_data_r;
    logic [tag_width_p-1:0] resp_tag_r;
    logic                   resp_err_r;

    // Decode
    logic [31:0]          addr;
    logic [hart_w_lp-1:0] hart;
    logic                 sel_msip, sel_cmp, sel_mtime, sel_meip;
    logic                 size8, size_ok, aligned, wide_ok, err;
    logic                 half;

    // Datapath
    logic [63:0] rdata;
    logic        accept;
    logic        wr_ok;
    logic        tick;

    function automatic logic [63:0] merge(
        input logic [63:0] old,
        input logic [63:0] d,
        input logic        wide,
        input logic        hi
    );
        if (wide) begin
            return d;
        end
        if (hi) begin
            return {d[31:0], old[31:0]};
        end
        return {old[63:32], d[31:0]};
    endfunction

    always_comb begin
        addr      = 32'(cmd_addr_i);
        half      = addr[2];
        hart      = '0;
        sel_msip  = 1'b0;
        sel_cmp   = 1'b0;
        sel_mtime = 1'b0;
        sel_meip  = 1'b0;
        size8     = (cmd_size_i == 2'b11);
        size_ok   = cmd_size_i[1];
        if (addr < msip_end_lp) begin
            sel_msip = 1'b1;
            hart     = hart_w_lp'(addr >> 2);
        end else if (addr >= cmp_base_lp && addr < cmp_end_lp) begin
            sel_cmp = 1'b1;
            hart    = hart_w_lp'((addr - cmp_base_lp) >> 3);
        end else if (addr[31:3] == mtime_lp[31:3]) begin
            sel_mtime = 1'b1;
        end else if (addr >= meip_base_lp && addr < meip_end_lp) begin
            sel_meip = 1'b1;
            hart     = hart_w_lp'((addr - meip_base_lp) >> 2);
        end
        aligned = size8 ? (addr[2:0] == 3'b000) : (addr[1:0] == 2'b00);
        // Only the 64-bit registers accept 8-byte accesses.
        wide_ok = ~size8 | sel_cmp | sel_mtime;
        err     = ~(sel_msip | sel_cmp | sel_mtime | sel_meip)
                | ~size_ok | ~aligned | ~wide_ok;
    end

    // Read data from pre-write state; narrow reads of 64-bit registers
    // return the selected half zero-extended.
    always_comb begin
        rdata = '0;
        if (sel_msip) begin
            rdata = {63'b0, msip_r[hart]};
        end else if (sel_meip) begin
            rdata = {63'b0, meip_r[hart]};
        end else if (sel_cmp) begin
            if (size8) begin
                rdata = mtimecmp_r[hart];
            end else if (half) begin
                rdata = {32'b0, mtimecmp_r[hart][63:32]};
            end else begin
                rdata = {32'b0, mtimecmp_r[hart][31:0]};
            end
        end else if (sel_mtime) begin
            if (size8) begin
                rdata = mtime_r;
            end else if (half) begin
                rdata = {32'b0, mtime_r[63:32]};
            end else begin
                rdata = {32'b0, mtime_r[31:0]};
            end
        end
    end

    assign accept = (state_r == e_ready) & cmd_v_i;
    assign wr_ok  = accept & cmd_w_i & ~err;
    assign tick   = (pre_r == pre_max_lp);

    // Handshake FSM
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_ready;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_ready: if (cmd_v_i)     state_n = e_resp;
            e_resp:  if (resp_yumi_i) state_n = e_ready;
        endcase
    end

    // Response register, held stable while waiting for yumi
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            resp_data_r <= '0;
            resp_tag_r  <= '0;
            resp_err_r  <= 1'b0;
        end else if (accept) begin
            resp_data_r <= (cmd_w_i | err) ? 64'b0 : rdata;
            resp_tag_r  <= cmd_tag_i;
            resp_err_r  <= err;
        end
    end

    // Prescaler and mtime; a write wins over the tick and restarts
    // the prescaler.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pre_r   <= '0;
            mtime_r <= '0;
        end else if (wr_ok & sel_mtime) begin
            pre_r   <= '0;
            mtime_r <= merge(mtime_r, cmd_data_i, size8, half);
        end else begin
            pre_r <= tick ? '0 : pre_r + 1'b1;
            if (tick) begin
                mtime_r <= mtime_r + 64'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < num_core_p; i++) begin
                mtimecmp_r[i] <= reset_mtimecmp_p;
            end
        end else if (wr_ok & sel_cmp) begin
            mtimecmp_r[hart] <= merge(mtimecmp_r[hart], cmd_data_i, size8, half);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            msip_r <= '0;
            meip_r <= '0;
        end else begin
            if (wr_ok & sel_msip) begin
                msip_r[hart] <= cmd_data_i[0];
            end
            if (wr_ok & sel_meip) begin
                meip_r[hart] <= cmd_data_i[0];
            end
        end
    end

    // Compare of registered values, so the level lags mtime/mtimecmp
    // by one cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            timer_irq_r <= '0;
        end else begin
            for (int i = 0; i < num_core_p; i++) begin
                timer_irq_r[i] <= (mtime_r >= mtimecmp_r[i]);
            end
        end
    end

    assign cmd_ready_o    = (state_r == e_ready);
    assign resp_v_o       = (state_r == e_resp);
    assign resp_data_o    = resp_data_r;
    assign resp_tag_o     = resp_tag_r;
    assign resp_err_o     = resp_err_r;
    assign soft_irq_o     = msip_r;
    assign timer_irq_o    = timer_irq_r;
    assign external_irq_o = meip_r;

endmodule
